// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forward-select
// encoding and the shadow-slot record that tracks in-flight destinations.
package hazard_pkg;

    localparam int unsigned RIDX_W = 8;  // widest register index a slot can hold
    localparam int unsigned SCNT_W = 2;  // load-use down-counter, covers LOAD_LAT up to 4

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [RIDX_W-1:0] rd;
        logic              wr;
        logic              ld;
    } slot_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forward select for the instruction in EX: MEM beats WB, r0 never
// forwards, and a load still in MEM is left to the WB path.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [RIDX_W-1:0] src_i,
    input  slot_t             mem_i,
    input  logic [RIDX_W-1:0] wb_rd_i,
    input  logic              wb_wr_i,
    output fwd_sel_e          sel_c
);

    logic mem_hit_c;
    logic wb_hit_c;

    always_comb begin
        mem_hit_c = mem_i.wr && !mem_i.ld && (mem_i.rd == src_i) && (src_i != '0);
        wb_hit_c  = wb_wr_i && (wb_rd_i == src_i) && (src_i != '0);
        sel_c     = FWD_RF;
        if (mem_hit_c) begin
            sel_c = FWD_MEM;
        end else if (wb_hit_c) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage core: shadows EX/MEM/WB
// destinations and decides stall, bubble, flush and forward selects in-cycle.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr,
    input  logic                  id_memrd,
    input  logic                  ex_redirect,
    output logic                  stall_if,
    output logic                  bubble_ex,
    output logic                  flush_id,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cycles
);

    slot_t             ex_q, ex_d;
    slot_t             mem_q, mem_d;
    logic [RIDX_W-1:0] ex_rs_q, ex_rs_d;
    logic [RIDX_W-1:0] ex_rt_q, ex_rt_d;
    logic [RIDX_W-1:0] wb_rd_q, wb_rd_d;
    logic              wb_wr_q, wb_wr_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [RIDX_W-1:0] rs_eff_c, rt_eff_c;
    logic              lu_haz_c, so_haz_c, stall_req_c, stall_c;
    fwd_sel_e          sel_a_c, sel_b_c;

    // An unused source is stored as r0 so it can never match a writer.
    function automatic logic hit(input logic [RIDX_W-1:0] s,
                                 input logic [RIDX_W-1:0] rd,
                                 input logic              wr);
        return wr && (rd == s) && (s != '0);
    endfunction

    always_comb begin
        rs_eff_c = id_use_rs ? RIDX_W'(id_rs) : '0;
        rt_eff_c = id_use_rt ? RIDX_W'(id_rt) : '0;

        lu_haz_c = id_valid && ex_q.ld &&
                   (hit(rs_eff_c, ex_q.rd, ex_q.wr) || hit(rt_eff_c, ex_q.rd, ex_q.wr));
        so_haz_c = id_valid &&
                   (hit(rs_eff_c, ex_q.rd, ex_q.wr)   || hit(rt_eff_c, ex_q.rd, ex_q.wr)   ||
                    hit(rs_eff_c, mem_q.rd, mem_q.wr) || hit(rt_eff_c, mem_q.rd, mem_q.wr) ||
                    hit(rs_eff_c, wb_rd_q, wb_wr_q)   || hit(rt_eff_c, wb_rd_q, wb_wr_q));

        if (FWD_EN != 0) begin
            stall_req_c = lu_haz_c || (scnt_q != '0);
        end else begin
            stall_req_c = so_haz_c;
        end
        stall_c = stall_req_c && !ex_redirect;
    end

    fwd_select u_fwd_a (
        .src_i   (ex_rs_q),
        .mem_i   (mem_q),
        .wb_rd_i (wb_rd_q),
        .wb_wr_i (wb_wr_q),
        .sel_c   (sel_a_c)
    );

    fwd_select u_fwd_b (
        .src_i   (ex_rt_q),
        .mem_i   (mem_q),
        .wb_rd_i (wb_rd_q),
        .wb_wr_i (wb_wr_q),
        .sel_c   (sel_b_c)
    );

    assign stall_if     = stall_c;
    assign bubble_ex    = stall_req_c || ex_redirect;
    assign flush_id     = ex_redirect;
    assign fwd_a        = (FWD_EN != 0) ? sel_a_c : FWD_RF;
    assign fwd_b        = (FWD_EN != 0) ? sel_b_c : FWD_RF;
    assign stall_cycles = cnt_q;

    // Shadow pipeline advance, load-use down-counter and stall statistics.
    always_comb begin
        ex_d    = '0;
        ex_rs_d = '0;
        ex_rt_d = '0;
        mem_d   = ex_q;
        wb_rd_d = mem_q.rd;
        wb_wr_d = mem_q.wr;
        scnt_d  = scnt_q;
        cnt_d   = cnt_q;

        if (id_valid && !stall_req_c && !ex_redirect) begin
            ex_d.rd = RIDX_W'(id_rd);
            ex_d.wr = id_wr;
            ex_d.ld = id_memrd;
            ex_rs_d = rs_eff_c;
            ex_rt_d = rt_eff_c;
        end

        if (ex_redirect) begin
            scnt_d = '0;
        end else if ((FWD_EN != 0) && lu_haz_c) begin
            scnt_d = SCNT_W'(LOAD_LAT - 1);
        end else if (scnt_q != '0) begin
            scnt_d = scnt_q - 1'b1;
        end

        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= '0;
            ex_rs_q <= '0;
            ex_rt_q <= '0;
            mem_q   <= '0;
            wb_rd_q <= '0;
            wb_wr_q <= 1'b0;
            scnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            ex_rs_q <= ex_rs_d;
            ex_rt_q <= ex_rt_d;
            mem_q   <= mem_d;
            wb_rd_q <= wb_rd_d;
            wb_wr_q <= wb_wr_d;
            scnt_q  <= scnt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
